// File: rtl/sd_sched_pkg.sv
// rtl/sd_sched_pkg.sv - shared types and constants for the SD sector scheduler
package sd_sched_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_STREAM,
        ST_DONE
    } state_e;

    localparam logic [3:0] CARD_STAT_IDLE = 4'd8;
    localparam int         SECTOR_BYTES   = 512;
    localparam int         SECTOR_AW      = $clog2(SECTOR_BYTES);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first request at/after ptr wins
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sd_sector_scheduler.sv
// rtl/sd_sector_scheduler.sv - round-robin sharing of the single-sector SD read engine
// Expands burst requests into back-to-back sector reads and routes bytes to the granted client.
module sd_sector_scheduler
    import sd_sched_pkg::*;
#(
    parameter int  NUM_REQ     = 2,
    parameter int  COUNT_W     = 16,
    parameter int  TIMEOUT_CYC = 50_000_000,
    parameter int  SIMULATION  = 0,
    localparam int ADDR_W      = COUNT_W + SECTOR_AW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*32-1:0]        req_sector,
    input  logic [NUM_REQ*COUNT_W-1:0]   req_count,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         req_err,
    output logic [NUM_REQ-1:0]           out_valid,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [7:0]                   out_byte,
    output logic                         busy,
    input  logic [3:0]                   sd_card_stat,
    output logic                         sd_rstart,
    output logic [31:0]                  sd_rsector_no,
    input  logic                         sd_rbusy,
    input  logic                         sd_rdone,
    input  logic                         sd_outreq,
    input  logic [SECTOR_AW-1:0]         sd_outaddr,
    input  logic [7:0]                   sd_outbyte
);

    localparam int          IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          TO_CYC  = (SIMULATION != 0) ? 2000 : TIMEOUT_CYC;
    localparam logic [31:0] TO_LAST = 32'(TO_CYC - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [31:0]          sector_q, sector_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   idx_q, idx_d;
    logic [31:0]          wdog_q, wdog_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   out_valid_q;
    logic [ADDR_W-1:0]    out_addr_q;
    logic [7:0]           out_byte_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [COUNT_W-1:0]   idx_next;
    logic [COUNT_W-1:0]   sel_count;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign idx_next  = COUNT_W'(idx_q + 1'b1);
    assign sel_count = req_count[COUNT_W*arb_idx +: COUNT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_INIT;
            rr_q        <= '0;
            gidx_q      <= '0;
            sector_q    <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= '0;
            out_addr_q  <= '0;
            out_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gidx_q      <= gidx_d;
            sector_q    <= sector_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            out_valid_q <= '0;
            if (state_q == ST_STREAM && sd_outreq) begin
                out_valid_q <= gnt_oh;
                out_addr_q  <= {idx_q, sd_outaddr};
                out_byte_q  <= sd_outbyte;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        sector_d = sector_q;
        count_d  = count_q;
        idx_d    = idx_q;
        wdog_d   = wdog_q;
        err_d    = err_q;
        case (state_q)
            ST_WAIT_INIT: begin
                if (sd_card_stat == CARD_STAT_IDLE && !sd_rbusy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (|req_valid) begin
                    gidx_d   = arb_idx;
                    rr_d     = (32'(arb_idx) == 32'(NUM_REQ - 1)) ? '0 : IW'(arb_idx + 1'b1);
                    sector_d = req_sector[32*arb_idx +: 32];
                    count_d  = sel_count;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    state_d  = (sel_count == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!sd_rbusy) begin
                    wdog_d  = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                wdog_d = wdog_q + 1'b1;
                if (wdog_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (sd_rbusy) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                wdog_d = wdog_q + 1'b1;
                // A sector completing on the expiry cycle still counts as success.
                if (sd_rdone) begin
                    idx_d    = idx_next;
                    sector_d = sector_q + 1'b1;
                    state_d  = (idx_next == count_q) ? ST_DONE : ST_ISSUE;
                end else if (wdog_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // After an abort the engine may still be busy; re-check readiness first.
                state_d = err_q ? ST_WAIT_INIT : ST_IDLE;
            end
            default: state_d = ST_WAIT_INIT;
        endcase
    end

    always_comb begin
        gnt_oh         = '0;
        gnt_oh[gidx_q] = 1'b1;
    end

    always_comb begin
        req_ack   = '0;
        req_done  = '0;
        req_err   = 1'b0;
        busy      = 1'b0;
        sd_rstart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ack = arb_grant;
                busy    = |req_valid;
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                sd_rstart = !sd_rbusy;
            end
            ST_WAIT_BUSY, ST_STREAM: busy = 1'b1;
            ST_DONE: begin
                req_done = gnt_oh;
                req_err  = err_q;
            end
            default: ;
        endcase
    end

    assign sd_rsector_no = sector_q;
    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_byte      = out_byte_q;

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// tb/tb_sd_sector_scheduler.sv - directed self-checking bench for sd_sector_scheduler
module tb_sd_sector_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [63:0] req_sector;
    logic [31:0] req_count;
    logic [1:0]  req_ack, req_done, out_valid;
    logic        req_err, busy;
    logic [24:0] out_addr;
    logic [7:0]  out_byte;
    logic [3:0]  sd_card_stat;
    logic        sd_rstart;
    logic [31:0] sd_rsector_no;
    logic        sd_rbusy = 1'b0, sd_rdone = 1'b0, sd_outreq = 1'b0;
    logic [8:0]  sd_outaddr = '0;
    logic [7:0]  sd_outbyte = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic hold_busy = 1'b0;

    int          ack_log[$];
    int          done_log[$];
    int          err_log[$];
    logic [31:0] rstart_log[$];
    int          ack_cyc, done_cyc, rstart_cyc;
    int          mon_client = 0;
    int          byte_cnt   = 0;
    logic [24:0] mon_addr   = '0;

    always #5 clk = ~clk;

    sd_sector_scheduler #(
        .NUM_REQ    (2),
        .COUNT_W    (16),
        .SIMULATION (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_sector    (req_sector),
        .req_count     (req_count),
        .req_ack       (req_ack),
        .req_done      (req_done),
        .req_err       (req_err),
        .out_valid     (out_valid),
        .out_addr      (out_addr),
        .out_byte      (out_byte),
        .busy          (busy),
        .sd_card_stat  (sd_card_stat),
        .sd_rstart     (sd_rstart),
        .sd_rsector_no (sd_rsector_no),
        .sd_rbusy      (sd_rbusy),
        .sd_rdone      (sd_rdone),
        .sd_outreq     (sd_outreq),
        .sd_outaddr    (sd_outaddr),
        .sd_outbyte    (sd_outbyte)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [1:0] v);
        return v[1] ? 1 : 0;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (|req_ack) seen = 1;
        end
        chk(tag, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (|req_done) seen = 1;
        end
        chk(tag, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_log.delete();
        done_log.delete();
        err_log.delete();
        rstart_log.delete();
    endtask

    // Engine model: busy one cycle after rstart, 512 bytes, rdone with the last byte.
    initial begin
        forever begin
            @(negedge clk);
            if (sd_rstart === 1'b1) begin
                @(posedge clk);
                #1;
                sd_rbusy = 1'b1;
                @(posedge clk);
                #1;
                for (int b = 0; b < 512 && !hold_busy; b++) begin
                    sd_outreq  = 1'b1;
                    sd_outaddr = 9'(b);
                    sd_outbyte = 8'(b) ^ 8'h5A;
                    sd_rdone   = (b == 511);
                    @(posedge clk);
                    #1;
                end
                sd_outreq = 1'b0;
                sd_rdone  = 1'b0;
                while (hold_busy) @(posedge clk);
                #1;
                sd_rbusy = 1'b0;
            end
        end
    end

    initial begin
        logic [1:0] exp_v;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (|req_ack) begin
                    chk("ack_onehot", 64'($onehot(req_ack)), 1);
                    ack_log.push_back(oh2i(req_ack));
                    ack_cyc    = cyc;
                    mon_client = oh2i(req_ack);
                    mon_addr   = '0;
                    byte_cnt   = 0;
                end
                if (|req_done) begin
                    done_log.push_back(oh2i(req_done));
                    err_log.push_back(int'(req_err));
                    done_cyc = cyc;
                end
                if (sd_rstart) begin
                    rstart_log.push_back(sd_rsector_no);
                    rstart_cyc = cyc;
                end
                if (|out_valid) begin
                    exp_v = (mon_client == 1) ? 2'b10 : 2'b01;
                    chk("out_valid_client", out_valid, exp_v);
                    chk("out_addr", out_addr, mon_addr);
                    chk("out_byte", out_byte, mon_addr[7:0] ^ 8'h5A);
                    mon_addr++;
                    byte_cnt++;
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 2'b00;
        req_sector   = '0;
        req_count    = '0;
        sd_card_stat = 4'd3;
        step(3);
        @(negedge clk);
        chk("rst_ctrl", {req_ack, req_done, req_err, out_valid, busy, sd_rstart}, 9'd0);
        chk("rst_data", {sd_rsector_no, out_addr, out_byte}, 65'd0);

        // 1+2: card not ready, then three-sector burst from client 0
        step(1);
        rst        = 1'b0;
        req_sector = {32'd0, 32'd100};
        req_count  = {16'd0, 16'd3};
        req_valid  = 2'b01;
        step(10);
        chk("notready_ack", ack_log.size(), 0);
        chk("notready_rstart", rstart_log.size(), 0);
        sd_card_stat = 4'd8;
        @(negedge clk);
        chk("ack_not_early", req_ack, 2'b00);
        @(negedge clk);
        chk("ack_first_idle", req_ack, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("busy_in_burst", busy, 1'b1);
        wait_done(2000, "burst3_done");
        chk("burst3_nstart", rstart_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("burst3_sector", rstart_log[i], 100 + i);
        chk("burst3_ndone", done_log.size(), 1);
        chk("burst3_done_client", done_log[0], 0);
        chk("burst3_err", err_log[0], 0);
        chk("burst3_bytes", byte_cnt, 1536);
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);

        // 4: zero-count burst from client 1
        step(1);
        clear_logs();
        req_sector = {32'd999, 32'd0};
        req_count  = {16'd0, 16'd0};
        req_valid  = 2'b10;
        wait_ack(10, "zero_ack_seen");
        req_valid = 2'b00;
        wait_done(5, "zero_done_seen");
        chk("zero_ack_client", ack_log[0], 1);
        chk("zero_done_client", done_log[0], 1);
        chk("zero_latency", (done_cyc - ack_cyc) <= 3, 1);
        chk("zero_no_rstart", rstart_log.size(), 0);

        // 3: both clients pending continuously for three bursts
        clear_logs();
        req_sector = {32'd300, 32'd200};
        req_count  = {16'd1, 16'd1};
        req_valid  = 2'b11;
        for (int i = 0; i < 3000 && ack_log.size() < 3; i++) step(1);
        req_valid = 2'b00;
        chk("rr_nack", ack_log.size(), 3);
        wait_done(1000, "rr_last_done");
        chk("rr_grant0", ack_log[0], 0);
        chk("rr_grant1", ack_log[1], 1);
        chk("rr_grant2", ack_log[2], 0);
        chk("rr_sector0", rstart_log[0], 200);
        chk("rr_sector1", rstart_log[1], 300);
        chk("rr_sector2", rstart_log[2], 200);
        chk("rr_done1", done_log[1], 1);
        step(5);
        chk("rr_no_extra", ack_log.size(), 3);

        // 5: engine hangs -> watchdog abort, then wait for engine idle
        clear_logs();
        hold_busy  = 1'b1;
        req_sector = {32'd600, 32'd500};
        req_count  = {16'd1, 16'd2};
        req_valid  = 2'b01;
        wait_ack(10, "to_ack_seen");
        req_valid = 2'b00;
        wait_done(2100, "to_done_seen");
        chk("to_err", err_log[0], 1);
        chk("to_done_client", done_log[0], 0);
        chk("to_window", ((done_cyc - rstart_cyc) >= 2000) && ((done_cyc - rstart_cyc) <= 2003), 1);
        req_valid = 2'b10;
        step(50);
        chk("to_no_rstart", rstart_log.size(), 1);
        chk("to_no_ack", ack_log.size(), 1);
        hold_busy = 1'b0;
        wait_ack(20, "to_recover_ack");
        req_valid = 2'b00;
        wait_done(1000, "to_recover_done");
        chk("to_recover_client", ack_log[1], 1);
        chk("to_recover_sector", rstart_log[1], 600);
        chk("to_recover_err", err_log[1], 0);

        // 6: reset mid-stream with engine stuck busy, then sector wrap
        clear_logs();
        req_sector = {32'd0, 32'hFFFF_FFFF};
        req_count  = {16'd0, 16'd2};
        req_valid  = 2'b01;
        wait_ack(10, "wrap_ack_seen");
        req_valid = 2'b00;
        for (int i = 0; i < 100 && byte_cnt < 20; i++) step(1);
        chk("wrap_streaming", byte_cnt >= 20, 1);
        hold_busy = 1'b1;
        rst       = 1'b1;
        step(1);
        @(negedge clk);
        chk("midrst_ctrl", {req_ack, req_done, req_err, out_valid, busy, sd_rstart}, 9'd0);
        chk("midrst_data", {sd_rsector_no, out_addr, out_byte}, 65'd0);
        step(1);
        rst       = 1'b0;
        req_valid = 2'b01;
        step(20);
        chk("midrst_no_rstart", rstart_log.size(), 1);
        chk("midrst_no_ack", ack_log.size(), 1);
        hold_busy = 1'b0;
        wait_ack(20, "wrap2_ack_seen");
        req_valid = 2'b00;
        wait_done(1500, "wrap2_done_seen");
        chk("wrap_nstart", rstart_log.size(), 3);
        chk("wrap_first", rstart_log[1], 32'hFFFF_FFFF);
        chk("wrap_second", rstart_log[2], 32'd0);
        chk("wrap_ndone", done_log.size(), 1);
        chk("wrap_err", err_log[0], 0);
        chk("wrap_bytes", byte_cnt, 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
